// File: rtl/mvm_pkg.sv
// mvm_pkg: shared constants and types for the matrix-vector multiply result path.
package mvm_pkg;
  localparam int OWIDTH     = 32;
  localparam int NUM_OLANES = 27;
  localparam int LANEW      = $clog2(NUM_OLANES);
  typedef logic [OWIDTH-1:0] result_vec_t [0:NUM_OLANES-1];
  typedef enum logic {EMPTY, STREAM} drain_state_e;
endpackage

// File: rtl/mvm_result_drain_bank.sv
// result_bank: one captured lane-result vector with a lane-indexed read mux.
module result_bank
  import mvm_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  result_vec_t       i_data,
  input  logic [LANEW-1:0]  i_lane,
  output logic [OWIDTH-1:0] o_data
);
  result_vec_t r_mem;
  always_ff @(posedge clk)
    if (i_we) r_mem <= i_data;
  assign o_data = r_mem[i_lane];
endmodule

// File: rtl/mvm_result_drain.sv
// mvm_result_drain: captures engine result vectors into two banks and streams them lane by lane.
module mvm_result_drain
  import mvm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  result_vec_t       i_result,
  input  logic              i_valid,
  output logic [OWIDTH-1:0] o_data,
  output logic [LANEW-1:0]  o_lane,
  output logic              o_last,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [1:0]        o_level,
  output logic              o_overflow,
  input  logic              i_clr_overflow
);
  drain_state_e      r_state, w_state_nxt;
  logic              r_wptr, r_rptr, r_overflow;
  logic [1:0]        r_level;
  logic [LANEW-1:0]  r_lane;
  logic              w_xfer, w_last_acc, w_cap, w_drop;
  logic [OWIDTH-1:0] w_bank0, w_bank1;
  // A full store can still capture when the bank being released finishes this cycle.
  assign w_xfer     = o_valid & i_ready;
  assign w_last_acc = w_xfer & o_last;
  assign w_cap      = i_valid & ((r_level != 2'd2) | w_last_acc);
  assign w_drop     = i_valid & ~w_cap;
  result_bank u_bank0 (
    .clk(clk), .i_we(w_cap & ~r_wptr), .i_data(i_result), .i_lane(r_lane), .o_data(w_bank0)
  );
  result_bank u_bank1 (
    .clk(clk), .i_we(w_cap & r_wptr), .i_data(i_result), .i_lane(r_lane), .o_data(w_bank1)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= EMPTY;
    else      r_state <= w_state_nxt;
  always_comb
    w_state_nxt = (r_state == EMPTY) ? (w_cap ? STREAM : EMPTY)
                : ((w_last_acc && !w_cap && r_level == 2'd1) ? EMPTY : STREAM);
  always_comb begin
    o_valid = (r_state == STREAM);
    o_last  = o_valid & (r_lane == LANEW'(NUM_OLANES - 1));
    o_data  = o_valid ? (r_rptr ? w_bank1 : w_bank0) : '0;
  end
  assign o_lane     = r_lane;
  assign o_level    = r_level;
  assign o_overflow = r_overflow;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_level    <= 2'd0;
      r_lane     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_cap) r_wptr <= ~r_wptr;
      if (w_last_acc) r_rptr <= ~r_rptr;
      r_level    <= r_level + 2'(w_cap) - 2'(w_last_acc);
      if (w_xfer) r_lane <= o_last ? '0 : r_lane + 1'b1;
      r_overflow <= w_drop | (r_overflow & ~i_clr_overflow);
    end
endmodule

// File: tb/tb_mvm_result_drain.sv
// tb_mvm_result_drain: scoreboard bench for the result drain stream, overflow and reset behaviour.
module tb_mvm_result_drain;
  import mvm_pkg::*;
  logic              clk = 1'b0, rst = 1'b0;
  result_vec_t       i_result;
  logic              i_valid = 1'b0, i_ready = 1'b0, i_clr_overflow = 1'b0;
  logic [OWIDTH-1:0] o_data;
  logic [LANEW-1:0]  o_lane;
  logic              o_last, o_valid, o_overflow;
  logic [1:0]        o_level;

  mvm_result_drain dut (
    .clk(clk), .rst(rst), .i_result(i_result), .i_valid(i_valid),
    .o_data(o_data), .o_lane(o_lane), .o_last(o_last), .o_valid(o_valid),
    .i_ready(i_ready), .o_level(o_level), .o_overflow(o_overflow),
    .i_clr_overflow(i_clr_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OWIDTH-1:0] d;
    logic [LANEW-1:0]  l;
    logic              last;
  } beat_t;
  beat_t q[$];
  beat_t b;
  int tests = 0, fails = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  logic              stall_p = 1'b0, s_last;
  logic [OWIDTH-1:0] s_data;
  logic [LANEW-1:0]  s_lane;
  always @(negedge clk) begin
    if (!rst) stall_p = 1'b0;
    else begin
      if (stall_p) begin
        chk("hold_data", o_data, s_data);
        chk("hold_lane", 32'(o_lane), 32'(s_lane));
        chk("hold_last", 32'(o_last), 32'(s_last));
      end
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got lane %0d data %0h expected no beat", o_lane, o_data);
        end else begin
          b = q.pop_front();
          chk("beat_data", o_data, b.d);
          chk("beat_lane", 32'(o_lane), 32'(b.l));
          chk("beat_last", 32'(o_last), 32'(b.last));
        end
      end
      stall_p = o_valid && !i_ready;
      s_data  = o_data;
      s_lane  = o_lane;
      s_last  = o_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(int base, int step, bit keep);
    for (int k = 0; k < NUM_OLANES; k++) begin
      i_result[k] = OWIDTH'(base + step * k);
      if (keep) q.push_back({OWIDTH'(base + step * k), LANEW'(k), k == NUM_OLANES - 1});
    end
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_drain(string n);
    int c = 0;
    while ((q.size() != 0 || o_valid) && c < 400) begin
      tick();
      c++;
    end
    chk({n, "_drain_in_time"}, 32'(c < 400), 1);
    chk({n, "_queue_empty"}, q.size(), 0);
  endtask

  task automatic wait_lane(string n, int lane);
    int c = 0;
    while (!(o_valid && o_lane == LANEW'(lane)) && c < 100) begin
      tick();
      c++;
    end
    chk({n, "_lane_reached"}, 32'(c < 100), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    // 1: reset holds everything at zero even with i_valid toggling
    i_ready = 1'b1;
    for (int k = 0; k < NUM_OLANES; k++) i_result[k] = OWIDTH'(k + 50);
    repeat (4) begin
      i_valid = ~i_valid;
      tick();
    end
    i_valid = 1'b0;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", o_data, 0);
    chk("rst_lane", 32'(o_lane), 0);
    chk("rst_last", 32'(o_last), 0);
    chk("rst_level", 32'(o_level), 0);
    chk("rst_overflow", 32'(o_overflow), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", 32'(o_valid), 0);
    chk("post_rst_level", 32'(o_level), 0);

    // 2: single capture, continuous ready
    capture(1, 3, 1);
    chk("t2_valid", 32'(o_valid), 1);
    chk("t2_lane0", 32'(o_lane), 0);
    chk("t2_level1", 32'(o_level), 1);
    wait_drain("t2");
    chk("t2_level0", 32'(o_level), 0);
    chk("t2_valid_low", 32'(o_valid), 0);

    // 3: ready pattern 1,0,0,1
    capture(1000, 7, 1);
    n = 0;
    while ((q.size() != 0 || o_valid) && n < 400) begin
      i_ready = (n % 4 == 0) || (n % 4 == 3);
      tick();
      n++;
    end
    chk("t3_done", 32'(n < 400), 1);
    chk("t3_queue_empty", q.size(), 0);
    i_ready = 1'b1;

    // 4: third capture dropped while stalled, A and B stream back to back
    i_ready = 1'b0;
    capture(0, 1, 1);
    capture(100, 1, 1);
    capture(200, 1, 0);
    chk("t4_level2", 32'(o_level), 2);
    chk("t4_overflow", 32'(o_overflow), 1);
    i_ready = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (o_valid && n < 200);
    chk("t4_beats_no_bubble", n, 2 * NUM_OLANES);
    chk("t4_queue_empty", q.size(), 0);
    chk("t4_overflow_sticky", 32'(o_overflow), 1);
    i_clr_overflow = 1'b1;
    tick();
    i_clr_overflow = 1'b0;
    chk("t4_overflow_cleared", 32'(o_overflow), 0);

    // 5: set beats clear, then capture coincident with A's last beat at level 2
    i_ready = 1'b0;
    capture('h500, 1, 1);
    capture('h600, 1, 1);
    i_clr_overflow = 1'b1;
    capture('h700, 1, 0);
    chk("t5_set_wins", 32'(o_overflow), 1);
    tick();
    i_clr_overflow = 1'b0;
    chk("t5_cleared", 32'(o_overflow), 0);
    i_ready = 1'b1;
    wait_lane("t5", NUM_OLANES - 1);
    capture('h800, 1, 1);
    chk("t5_no_overflow", 32'(o_overflow), 0);
    chk("t5_level2", 32'(o_level), 2);
    chk("t5_next_lane0", 32'(o_lane), 0);
    chk("t5_next_valid", 32'(o_valid), 1);
    wait_drain("t5");

    // 6: async reset mid-vector
    capture('h900, 1, 1);
    wait_lane("t6", 10);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_valid", 32'(o_valid), 0);
    chk("t6_async_level", 32'(o_level), 0);
    chk("t6_async_lane", 32'(o_lane), 0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    tick();
    capture('hA00, 2, 1);
    chk("t6_restart_lane0", 32'(o_lane), 0);
    chk("t6_restart_data", o_data, 'hA00);
    wait_drain("t6");
    chk("t6_level0", 32'(o_level), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
